edf_ingress_scheduler: RTL

Earliest-deadline-first scheduler that moves frames from four per-port ingress queues (pointer FIFO + data FIFO per port) into the shared switch buffer (byte FIFO `sfifo` + pointer FIFO `ptr_sfifo`). It arbitrates between ports by deadline slack rather than plain round-robin, uses round-robin only to break ties, and drops errored or optionally late frames. It sits between the per-port MAC receive FIFOs and the switch core, and owns the system deadline timer used to stamp frames.

---
 rtl/edf_ingress_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/edf_ingress_scheduler.sv
// Earliest-deadline-first ingress scheduler: picks the pending port with the
// smallest signed deadline slack (round-robin on ties), copies its frame from
// the per-port data FIFO into the shared byte FIFO, then writes the frame
// pointer. Errored, empty and (optionally) late frames are drained and counted.
module edf_ingress_scheduler #(
  parameter int BP_THRESH = 14866,
  parameter bit DROP_LATE = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  ptr_empty,
  input  logic [63:0] ptr_dout,
  input  logic [63:0] dl_dout,
  output logic [3:0]  ptr_rd,
  output logic [3:0]  data_rd,
  input  logic [31:0] data_dout,
  input  logic [14:0] sfifo_cnt,
  input  logic        ptr_sfifo_full,
  output logic        sfifo_wr,
  output logic [7:0]  sfifo_din,
  output logic        ptr_sfifo_wr,
  output logic [15:0] ptr_sfifo_din,
  output logic [15:0] now,
  output logic [15:0] drop_cnt
);

  localparam logic [14:0] BP_LIM = 15'(BP_THRESH);

  typedef enum logic [2:0] {IDLE, GRANT, READ, DRAIN1, DRAIN2, PTRWR} state_t;

  state_t             state, state_nx;
  logic [1:0]         sel, rr, win, scan;
  logic [10:0]        len, cnt;
  logic [1:0]         err;
  logic               late, rd_d1, found, bp, drop;
  logic signed [15:0] slack [4];
  logic signed [15:0] best;
  logic [15:0]        head;

  assign head = ptr_dout[{sel, 4'b0000} +: 16];
  assign bp   = (sfifo_cnt > BP_LIM) | ptr_sfifo_full;
  assign drop = (|err) | (len == 11'd0) | (DROP_LATE && late);

  // Modular slack of every head; the sign bit marks a missed deadline.
  always_comb begin
    for (int i = 0; i < 4; i++) slack[i] = dl_dout[16*i +: 16] - now;
  end

  // Minimum-slack search starting at rr; strict '<' keeps the first tie found.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win   = rr;
    best  = '0;
    found = 1'b0;
    scan  = rr;
    for (int k = 0; k < 4; k++) begin
      scan = rr + k[1:0];
      if (!ptr_empty[scan] && (!found || slack[scan] < best)) begin
        found = 1'b1;
        win   = scan;
        best  = slack[scan];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nx      = state;
    ptr_rd        = '0;
    data_rd       = '0;
    ptr_sfifo_wr  = 1'b0;
    ptr_sfifo_din = '0;
    case (state)
      IDLE:   if (found && !bp) state_nx = GRANT;
      GRANT: begin
        ptr_rd[sel] = 1'b1;
        state_nx    = (head[10:0] == 11'd0) ? PTRWR : READ;
      end
      READ: begin
        data_rd[sel] = 1'b1;
        if (cnt == 11'd1) state_nx = DRAIN1;
      end
      DRAIN1: state_nx = DRAIN2;
      DRAIN2: state_nx = PTRWR;
      PTRWR: begin
        if (!drop) begin
          ptr_sfifo_wr  = 1'b1;
          ptr_sfifo_din = {late, 4'b0001 << sel, len};
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Grant bookkeeping: winner and rr at the decision, frame header at the pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel  <= '0;
      rr   <= '0;
      len  <= '0;
      err  <= '0;
      late <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (state_nx == GRANT) begin
          sel <= win;
          rr  <= win + 2'd1;
        end
        GRANT: begin
          len  <= head[10:0];
          err  <= head[15:14];
          late <= slack[sel][15];
          cnt  <= head[10:0];
        end
        READ:    cnt <= cnt - 11'd1;
        default: ;
      endcase
    end
  end

  // Free-running deadline timer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) now <= '0;
    else       now <= now + 16'd1;
  end

  // Saturating drop counter, bumped when a dropped frame finishes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                               drop_cnt <= '0;
    else if (state == PTRWR && drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  // Byte path: data FIFO output arrives one cycle after the read, then registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_d1     <= 1'b0;
      sfifo_wr  <= 1'b0;
      sfifo_din <= '0;
    end else begin
      rd_d1    <= |data_rd;
      sfifo_wr <= rd_d1 & ~drop;
      if (rd_d1) sfifo_din <= data_dout[{sel, 3'b000} +: 8];
    end
  end

endmodule
